// File: rtl/debug_cmd_decoder_pkg.sv
// rtl/debug_cmd_decoder_pkg.sv - command codes, request types, frame layout and FSM encoding
package debug_cmd_decoder_pkg;

   // Frame layout: {code[31:26], valid[25], type[24:16], addr[15:0]}
   localparam int NB_CODE         = 6;
   localparam int NB_TYPE         = 9;
   localparam int NB_ADDR         = 16;
   localparam int FRAME_CODE_LSB  = 26;
   localparam int FRAME_VALID_BIT = 25;
   localparam int FRAME_TYPE_LSB  = 16;
   localparam int FRAME_ADDR_LSB  = 0;

   // Command codes carried in frame[31:26]; code 0 is never issued by the link
   localparam logic [NB_CODE-1:0] CMD_START          = 6'h01;
   localparam logic [NB_CODE-1:0] CMD_RESET          = 6'h02;
   localparam logic [NB_CODE-1:0] CMD_LOAD_INSTR_LSB = 6'h03;
   localparam logic [NB_CODE-1:0] CMD_LOAD_INSTR_MSB = 6'h04;
   localparam logic [NB_CODE-1:0] CMD_REQ_DATA       = 6'h05;
   localparam logic [NB_CODE-1:0] CMD_MODE_GET       = 6'h06;
   localparam logic [NB_CODE-1:0] CMD_MODE_SET_CONT  = 6'h07;
   localparam logic [NB_CODE-1:0] CMD_MODE_SET_STEP  = 6'h08;
   localparam logic [NB_CODE-1:0] CMD_STEP           = 6'h09;
   localparam logic [NB_CODE-1:0] CMD_GOT_DATA       = 6'h0A;
   localparam logic [NB_CODE-1:0] CMD_GIB_DATA       = 6'h0B;

   // Debug read request types carried in frame[24:16]
   localparam logic [NB_TYPE-1:0] REQ_MEM_DATA         = 9'h001;
   localparam logic [NB_TYPE-1:0] REQ_REG_DATA         = 9'h002;
   localparam logic [NB_TYPE-1:0] REQ_LATCH_FETCH_DATA = 9'h004;
   localparam logic [NB_TYPE-1:0] REQ_LATCH_FETCH_CTRL = 9'h008;
   localparam logic [NB_TYPE-1:0] REQ_LATCH_DECO_CTRL  = 9'h010;
   localparam logic [NB_TYPE-1:0] REQ_LATCH_DECO_DATA  = 9'h020;
   localparam logic [NB_TYPE-1:0] REQ_LATCH_EXEC_DATA  = 9'h040;
   localparam logic [NB_TYPE-1:0] REQ_LATCH_EXEC_CTRL  = 9'h080;
   localparam logic [NB_TYPE-1:0] REQ_LATCH_MEM_CTRL   = 9'h100;

   // Word returned when the debug controllers never answer a read
   localparam logic [31:0] TIMEOUT_WORD = 32'hDEAD_BEEF;

   // Read handshake FSM
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RD_WAIT = 2'd1,
      ST_HOLD    = 2'd2
   } dbg_state_t;

endpackage

// File: rtl/debug_cmd_decoder_frame_edge_detect.sv
// rtl/debug_cmd_decoder_frame_edge_detect.sv - one-shot accept strobe and field split for incoming frames
module frame_edge_detect
   import debug_cmd_decoder_pkg::*;
#(
   parameter int NB_CONTROL_FRAME = 32
)
(
   input  logic                        i_clock,
   input  logic                        i_reset,
   input  logic [NB_CONTROL_FRAME-1:0] i_frame,
   output logic                        o_accept,
   output logic [NB_CODE-1:0]          o_code,
   output logic [NB_TYPE-1:0]          o_type,
   output logic [NB_ADDR-1:0]          o_addr
);

   logic valid_q;

   // remember last cycle's valid bit so a frame held for many cycles executes once
   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         valid_q <= 1'b0;
      end else begin
         valid_q <= i_frame[FRAME_VALID_BIT];
      end
   end

   assign o_accept = i_frame[FRAME_VALID_BIT] & ~valid_q;
   assign o_code   = i_frame[FRAME_CODE_LSB +: NB_CODE];
   assign o_type   = i_frame[FRAME_TYPE_LSB +: NB_TYPE];
   assign o_addr   = i_frame[FRAME_ADDR_LSB +: NB_ADDR];

endmodule

// File: rtl/debug_cmd_decoder.sv
// rtl/debug_cmd_decoder.sv - MicroBlaze control-frame decoder for CPU control, imem load and debug reads (option: DEBUG_CMD_ERR_EN)
module debug_cmd_decoder
   import debug_cmd_decoder_pkg::*;
#(
   parameter int NB_CONTROL_FRAME = 32,
   parameter int NB_INSTR         = 32,
   parameter int NB_INSTR_ADDR    = 9,
   parameter int RD_TIMEOUT       = 15
)
(
   input  logic                        i_clock,
   input  logic                        i_reset,
   input  logic [NB_CONTROL_FRAME-1:0] i_frame_from_blaze,
   output logic [NB_CONTROL_FRAME-1:0] o_frame_to_blaze,
   output logic                        o_cpu_reset,
   output logic                        o_run,
   output logic                        o_step,
   output logic                        o_mode_step,
   output logic                        o_imem_we,
   output logic [NB_INSTR_ADDR-1:0]    o_imem_addr,
   output logic [NB_INSTR-1:0]         o_imem_data,
   output logic                        o_rd_req,
   output logic [NB_TYPE-1:0]          o_rd_type,
   output logic [NB_ADDR-1:0]          o_rd_addr,
   input  logic [NB_INSTR-1:0]         i_rd_data,
   input  logic                        i_rd_valid
);

   localparam int                 NB_TIMER     = $clog2(RD_TIMEOUT + 1);
   localparam logic [NB_TIMER-1:0] TIMEOUT_LAST = NB_TIMER'(RD_TIMEOUT);

   logic               accept;
   logic [NB_CODE-1:0] cmd_code;
   logic [NB_TYPE-1:0] cmd_type;
   logic [NB_ADDR-1:0] cmd_addr;

   dbg_state_t                  state_q,     state_d;
   logic [NB_TIMER-1:0]         timer_q,     timer_d;
   logic [NB_CONTROL_FRAME-1:0] frame_q,     frame_d;
   logic                        cpu_reset_q, cpu_reset_d;
   logic                        run_q,       run_d;
   logic                        step_q,      step_d;
   logic                        mode_step_q, mode_step_d;
   logic                        imem_we_q,   imem_we_d;
   logic [NB_INSTR_ADDR-1:0]    imem_addr_q, imem_addr_d;
   logic [NB_INSTR-1:0]         imem_data_q, imem_data_d;
   logic                        rd_req_q,    rd_req_d;
   logic [NB_TYPE-1:0]          rd_type_q,   rd_type_d;
   logic [NB_ADDR-1:0]          rd_addr_q,   rd_addr_d;
   logic [NB_INSTR_ADDR-1:0]    wr_ptr_q,    wr_ptr_d;
   logic                        lsb_flag_q,  lsb_flag_d;
   logic [NB_ADDR-1:0]          lsb_data_q,  lsb_data_d;

   // REQ_DATA with type 0 may be redirected to the ignored-command counter
   logic                        count_query;
   logic [NB_CONTROL_FRAME-1:0] count_word;

   frame_edge_detect #(
      .NB_CONTROL_FRAME (NB_CONTROL_FRAME)
   ) u_frame_edge_detect (
      .i_clock  (i_clock),
      .i_reset  (i_reset),
      .i_frame  (i_frame_from_blaze),
      .o_accept (accept),
      .o_code   (cmd_code),
      .o_type   (cmd_type),
      .o_addr   (cmd_addr)
   );

`ifdef DEBUG_CMD_ERR_EN
   logic [7:0] err_cnt_q;
   logic       cmd_ignored;

   // flag accepted commands that end up having no effect
   always_comb begin
      cmd_ignored = 1'b0;
      if (accept) begin
         case (cmd_code)
            CMD_RESET, CMD_LOAD_INSTR_LSB,
            CMD_MODE_SET_CONT, CMD_MODE_SET_STEP: cmd_ignored = 1'b0;
            CMD_START:                            cmd_ignored = mode_step_q;
            CMD_STEP:                             cmd_ignored = ~mode_step_q;
            CMD_LOAD_INSTR_MSB:                   cmd_ignored = ~lsb_flag_q;
            CMD_REQ_DATA, CMD_MODE_GET:           cmd_ignored = (state_q != ST_IDLE);
            CMD_GOT_DATA, CMD_GIB_DATA:           cmd_ignored = (state_q != ST_HOLD);
            default:                              cmd_ignored = 1'b1;
         endcase
      end
   end

   // saturating count of ignored commands, cleared by the RESET command
   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         err_cnt_q <= 8'd0;
      end else if (accept && (cmd_code == CMD_RESET)) begin
         err_cnt_q <= 8'd0;
      end else if (cmd_ignored && (err_cnt_q != 8'hFF)) begin
         err_cnt_q <= err_cnt_q + 8'd1;
      end
   end

   assign count_query = (cmd_type == '0);
   assign count_word  = {{(NB_CONTROL_FRAME-8){1'b0}}, err_cnt_q};
`else
   assign count_query = 1'b0;
   assign count_word  = '0;
`endif

   // next-state and registered-output decode for the accepted command
   always_comb begin
      state_d     = state_q;
      timer_d     = timer_q;
      frame_d     = frame_q;
      run_d       = run_q;
      mode_step_d = mode_step_q;
      imem_addr_d = imem_addr_q;
      imem_data_d = imem_data_q;
      rd_type_d   = rd_type_q;
      rd_addr_d   = rd_addr_q;
      wr_ptr_d    = wr_ptr_q;
      lsb_flag_d  = lsb_flag_q;
      lsb_data_d  = lsb_data_q;
      cpu_reset_d = 1'b0;
      step_d      = 1'b0;
      imem_we_d   = 1'b0;
      rd_req_d    = 1'b0;

      // outstanding read: capture the answer or give up after RD_TIMEOUT cycles
      if (state_q == ST_RD_WAIT) begin
         if (i_rd_valid) begin
            frame_d = i_rd_data;
            state_d = ST_HOLD;
         end else if (timer_q == TIMEOUT_LAST) begin
            frame_d = TIMEOUT_WORD;
            state_d = ST_HOLD;
         end else begin
            timer_d = timer_q + 1'b1;
         end
      end

      if (accept) begin
         case (cmd_code)
            CMD_RESET: begin
               cpu_reset_d = 1'b1;
               run_d       = 1'b0;
               wr_ptr_d    = '0;
               lsb_flag_d  = 1'b0;
               state_d     = ST_IDLE;
               timer_d     = '0;
            end
            CMD_START: begin
               if (!mode_step_q) begin
                  run_d = 1'b1;
               end
            end
            CMD_STEP: begin
               if (mode_step_q) begin
                  step_d = 1'b1;
               end
            end
            CMD_MODE_SET_CONT: begin
               mode_step_d = 1'b0;
               run_d       = 1'b0;
            end
            CMD_MODE_SET_STEP: begin
               mode_step_d = 1'b1;
               run_d       = 1'b0;
            end
            CMD_LOAD_INSTR_LSB: begin
               lsb_data_d = cmd_addr;
               lsb_flag_d = 1'b1;
            end
            CMD_LOAD_INSTR_MSB: begin
               if (lsb_flag_q) begin
                  imem_we_d   = 1'b1;
                  imem_addr_d = wr_ptr_q;
                  imem_data_d = {cmd_addr, lsb_data_q};
                  wr_ptr_d    = wr_ptr_q + 1'b1;
                  lsb_flag_d  = 1'b0;
               end
            end
            CMD_REQ_DATA: begin
               if (state_q == ST_IDLE) begin
                  if (count_query) begin
                     frame_d = count_word;
                     state_d = ST_HOLD;
                  end else begin
                     rd_req_d  = 1'b1;
                     rd_type_d = cmd_type;
                     rd_addr_d = cmd_addr;
                     state_d   = ST_RD_WAIT;
                     timer_d   = '0;
                  end
               end
            end
            CMD_MODE_GET: begin
               if (state_q == ST_IDLE) begin
                  frame_d = {{(NB_CONTROL_FRAME-1){1'b0}}, mode_step_q};
                  state_d = ST_HOLD;
               end
            end
            CMD_GOT_DATA: begin
               if (state_q == ST_HOLD) begin
                  state_d = ST_IDLE;
               end
            end
            default: begin
               // GIB_DATA keeps re-presenting the held word; anything else is dropped
            end
         endcase
      end
   end

   // state and output registers
   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         state_q     <= ST_IDLE;
         timer_q     <= '0;
         frame_q     <= '0;
         cpu_reset_q <= 1'b0;
         run_q       <= 1'b0;
         step_q      <= 1'b0;
         mode_step_q <= 1'b0;
         imem_we_q   <= 1'b0;
         imem_addr_q <= '0;
         imem_data_q <= '0;
         rd_req_q    <= 1'b0;
         rd_type_q   <= '0;
         rd_addr_q   <= '0;
         wr_ptr_q    <= '0;
         lsb_flag_q  <= 1'b0;
         lsb_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         timer_q     <= timer_d;
         frame_q     <= frame_d;
         cpu_reset_q <= cpu_reset_d;
         run_q       <= run_d;
         step_q      <= step_d;
         mode_step_q <= mode_step_d;
         imem_we_q   <= imem_we_d;
         imem_addr_q <= imem_addr_d;
         imem_data_q <= imem_data_d;
         rd_req_q    <= rd_req_d;
         rd_type_q   <= rd_type_d;
         rd_addr_q   <= rd_addr_d;
         wr_ptr_q    <= wr_ptr_d;
         lsb_flag_q  <= lsb_flag_d;
         lsb_data_q  <= lsb_data_d;
      end
   end

   assign o_frame_to_blaze = frame_q;
   assign o_cpu_reset      = cpu_reset_q;
   assign o_run            = run_q;
   assign o_step           = step_q;
   assign o_mode_step      = mode_step_q;
   assign o_imem_we        = imem_we_q;
   assign o_imem_addr      = imem_addr_q;
   assign o_imem_data      = imem_data_q;
   assign o_rd_req         = rd_req_q;
   assign o_rd_type        = rd_type_q;
   assign o_rd_addr        = rd_addr_q;

endmodule

// File: tb/tb_debug_cmd_decoder.sv
// tb/tb_debug_cmd_decoder.sv - directed self-checking bench for debug_cmd_decoder
module tb_debug_cmd_decoder;
   import debug_cmd_decoder_pkg::*;

   logic        tb_clock_i = 1'b0;
   logic        tb_reset   = 1'b0;
   logic [31:0] frame_from_blaze = '0;
   logic [31:0] frame_to_blaze;
   logic        cpu_reset, run, step, mode_step, imem_we, rd_req;
   logic [8:0]  imem_addr;
   logic [31:0] imem_data;
   logic [8:0]  rd_type;
   logic [15:0] rd_addr;
   logic [31:0] rd_data  = '0;
   logic        rd_valid = 1'b0;

   int errors = 0;
   int checks = 0;

   int          n_cpu_reset = 0, n_step = 0, n_we = 0, n_rd_req = 0;
   logic [8:0]  last_we_addr = '0;
   logic [31:0] last_we_data = '0;

   always #5 tb_clock_i = ~tb_clock_i;

   debug_cmd_decoder dut (
      .i_clock            (tb_clock_i),
      .i_reset            (tb_reset),
      .i_frame_from_blaze (frame_from_blaze),
      .o_frame_to_blaze   (frame_to_blaze),
      .o_cpu_reset        (cpu_reset),
      .o_run              (run),
      .o_step             (step),
      .o_mode_step        (mode_step),
      .o_imem_we          (imem_we),
      .o_imem_addr        (imem_addr),
      .o_imem_data        (imem_data),
      .o_rd_req           (rd_req),
      .o_rd_type          (rd_type),
      .o_rd_addr          (rd_addr),
      .i_rd_data          (rd_data),
      .i_rd_valid         (rd_valid)
   );

   // count single-cycle pulses shortly after each active edge
   always @(posedge tb_clock_i) begin
      #2;
      if (cpu_reset) n_cpu_reset++;
      if (step)      n_step++;
      if (imem_we) begin
         n_we++;
         last_we_addr = imem_addr;
         last_we_data = imem_data;
      end
      if (rd_req) n_rd_req++;
   end

   task automatic send_cmd(input logic [5:0] code, input logic [8:0] typ, input logic [15:0] addr, input int hold);
      @(negedge tb_clock_i);
      frame_from_blaze = {code, 1'b1, typ, addr};
      repeat (hold) @(negedge tb_clock_i);
      frame_from_blaze[25] = 1'b0;
      @(negedge tb_clock_i);
   endtask

   task automatic give_rd(input logic [31:0] d);
      @(negedge tb_clock_i);
      rd_data  = d;
      rd_valid = 1'b1;
      @(negedge tb_clock_i);
      rd_valid = 1'b0;
      @(negedge tb_clock_i);
   endtask

   task automatic test_reset();
      repeat (3) @(negedge tb_clock_i);
      checks++; if ({cpu_reset, run, step, mode_step, imem_we, rd_req} !== 6'b0) begin errors++; $display("FAIL reset_ctrl: got %b expected 000000", {cpu_reset, run, step, mode_step, imem_we, rd_req}); end
      checks++; if (frame_to_blaze !== 32'h0) begin errors++; $display("FAIL reset_frame: got %h expected 00000000", frame_to_blaze); end
      checks++; if ({imem_addr, imem_data, rd_type, rd_addr} !== '0) begin errors++; $display("FAIL reset_data: got %h expected 0", {imem_addr, imem_data, rd_type, rd_addr}); end
      tb_reset = 1'b1;
      repeat (2) @(negedge tb_clock_i);
   endtask

   task automatic test_reset_cmd();
      int n0;
      send_cmd(CMD_START, 9'h0, 16'h0, 2);
      checks++; if (run !== 1'b1) begin errors++; $display("FAIL start_cont_run: got %b expected 1", run); end
      n0 = n_cpu_reset;
      send_cmd(CMD_RESET, 9'h0, 16'h0, 2);
      checks++; if (n_cpu_reset - n0 !== 1) begin errors++; $display("FAIL reset_pulse_hold2: got %0d pulses expected 1", n_cpu_reset - n0); end
      checks++; if (run !== 1'b0) begin errors++; $display("FAIL reset_run: got %b expected 0", run); end
      n0 = n_cpu_reset;
      send_cmd(CMD_RESET, 9'h0, 16'h0, 6);
      checks++; if (n_cpu_reset - n0 !== 1) begin errors++; $display("FAIL reset_pulse_hold6: got %0d pulses expected 1", n_cpu_reset - n0); end
   endtask

   task automatic test_step_mode();
      int n0;
      send_cmd(CMD_MODE_SET_STEP, 9'h0, 16'h0, 2);
      checks++; if (mode_step !== 1'b1) begin errors++; $display("FAIL mode_set_step: got %b expected 1", mode_step); end
      send_cmd(CMD_MODE_GET, 9'h0, 16'h0, 2);
      checks++; if (frame_to_blaze !== 32'h1) begin errors++; $display("FAIL mode_get_step: got %h expected 00000001", frame_to_blaze); end
      send_cmd(CMD_GOT_DATA, 9'h0, 16'h0, 2);
      n0 = n_step;
      send_cmd(CMD_STEP, 9'h0, 16'h0, 3);
      checks++; if (n_step - n0 !== 1) begin errors++; $display("FAIL step_pulse: got %0d pulses expected 1", n_step - n0); end
      send_cmd(CMD_START, 9'h0, 16'h0, 2);
      checks++; if (run !== 1'b0) begin errors++; $display("FAIL start_in_step: got run=%b expected 0", run); end
      send_cmd(CMD_MODE_SET_CONT, 9'h0, 16'h0, 2);
      n0 = n_step;
      send_cmd(CMD_STEP, 9'h0, 16'h0, 2);
      checks++; if (n_step - n0 !== 0) begin errors++; $display("FAIL step_in_cont: got %0d pulses expected 0", n_step - n0); end
      send_cmd(CMD_MODE_GET, 9'h0, 16'h0, 2);
      checks++; if (frame_to_blaze !== 32'h0) begin errors++; $display("FAIL mode_get_cont: got %h expected 00000000", frame_to_blaze); end
      send_cmd(CMD_GOT_DATA, 9'h0, 16'h0, 2);
   endtask

   task automatic test_imem_load();
      int n0;
      send_cmd(CMD_RESET, 9'h0, 16'h0, 2);
      n0 = n_we;
      send_cmd(CMD_LOAD_INSTR_LSB, 9'h0, 16'h0020, 2);
      send_cmd(CMD_LOAD_INSTR_MSB, 9'h0, 16'h2001, 2);
      checks++; if (n_we - n0 !== 1) begin errors++; $display("FAIL load0_we: got %0d strobes expected 1", n_we - n0); end
      checks++; if (last_we_addr !== 9'd0 || last_we_data !== 32'h2001_0020) begin errors++; $display("FAIL load0_word: got %0d/%h expected 0/20010020", last_we_addr, last_we_data); end
      send_cmd(CMD_LOAD_INSTR_LSB, 9'h0, 16'h1234, 2);
      send_cmd(CMD_LOAD_INSTR_MSB, 9'h0, 16'hABCD, 2);
      checks++; if (last_we_addr !== 9'd1 || last_we_data !== 32'hABCD_1234) begin errors++; $display("FAIL load1_word: got %0d/%h expected 1/abcd1234", last_we_addr, last_we_data); end
      n0 = n_we;
      send_cmd(CMD_LOAD_INSTR_MSB, 9'h0, 16'h7777, 2);
      checks++; if (n_we - n0 !== 0) begin errors++; $display("FAIL msb_without_lsb: got %0d strobes expected 0", n_we - n0); end
   endtask

   task automatic test_read();
      int n0;
      n0 = n_rd_req;
      send_cmd(CMD_REQ_DATA, REQ_LATCH_DECO_DATA, 16'h0001, 2);
      checks++; if (n_rd_req - n0 !== 1) begin errors++; $display("FAIL rd_req_pulse: got %0d expected 1", n_rd_req - n0); end
      checks++; if (rd_type !== 9'h020 || rd_addr !== 16'h0001) begin errors++; $display("FAIL rd_req_fields: got %h/%h expected 020/0001", rd_type, rd_addr); end
      give_rd(32'hCAFE_0001);
      checks++; if (frame_to_blaze !== 32'hCAFE_0001) begin errors++; $display("FAIL rd_data: got %h expected cafe0001", frame_to_blaze); end
      n0 = n_rd_req;
      send_cmd(CMD_REQ_DATA, REQ_REG_DATA, 16'h0002, 2);
      checks++; if (n_rd_req - n0 !== 0) begin errors++; $display("FAIL req_in_hold: got %0d requests expected 0", n_rd_req - n0); end
      send_cmd(CMD_GIB_DATA, 9'h0, 16'h0, 2);
      give_rd(32'h0BAD_0BAD);
      checks++; if (frame_to_blaze !== 32'hCAFE_0001) begin errors++; $display("FAIL hold_word: got %h expected cafe0001", frame_to_blaze); end
      send_cmd(CMD_GOT_DATA, 9'h0, 16'h0, 2);
      checks++; if (frame_to_blaze !== 32'hCAFE_0001) begin errors++; $display("FAIL got_data_word: got %h expected cafe0001", frame_to_blaze); end
   endtask

   task automatic test_timeout();
      int  n0;
      int  waited = 0;
      bit  seen = 1'b0;
      send_cmd(CMD_REQ_DATA, REQ_LATCH_FETCH_DATA, 16'h0007, 2);
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge tb_clock_i);
         waited = i + 1;
         if (frame_to_blaze === TIMEOUT_WORD) seen = 1'b1;
      end
      checks++; if (!seen) begin errors++; $display("FAIL timeout_word: got %h expected deadbeef", frame_to_blaze); end
      checks++; if (waited < 10 || waited > 20) begin errors++; $display("FAIL timeout_delay: got %0d cycles expected 10..20", waited); end
      send_cmd(CMD_GOT_DATA, 9'h0, 16'h0, 2);
      send_cmd(CMD_REQ_DATA, REQ_MEM_DATA, 16'h0004, 2);
      send_cmd(CMD_RESET, 9'h0, 16'h0, 2);
      repeat (20) @(negedge tb_clock_i);
      give_rd(32'h55AA_55AA);
      checks++; if (frame_to_blaze !== TIMEOUT_WORD) begin errors++; $display("FAIL reset_in_rd_wait: got %h expected deadbeef", frame_to_blaze); end
      n0 = n_rd_req;
      send_cmd(CMD_REQ_DATA, REQ_MEM_DATA, 16'h0005, 2);
      checks++; if (n_rd_req - n0 !== 1) begin errors++; $display("FAIL idle_after_reset: got %0d requests expected 1", n_rd_req - n0); end
      give_rd(32'h1234_5678);
      checks++; if (frame_to_blaze !== 32'h1234_5678) begin errors++; $display("FAIL rd_after_reset: got %h expected 12345678", frame_to_blaze); end
      send_cmd(CMD_GOT_DATA, 9'h0, 16'h0, 2);
   endtask

   task automatic test_async_reset();
      int n0;
      send_cmd(CMD_START, 9'h0, 16'h0, 2);
      send_cmd(CMD_LOAD_INSTR_LSB, 9'h0, 16'h1111, 2);
      send_cmd(CMD_LOAD_INSTR_MSB, 9'h0, 16'h2222, 2);
      send_cmd(CMD_LOAD_INSTR_LSB, 9'h0, 16'h3333, 2);
      send_cmd(CMD_REQ_DATA, REQ_REG_DATA, 16'h0003, 2);
      @(negedge tb_clock_i);
      #2 tb_reset = 1'b0;
      #1;
      checks++; if ({run, frame_to_blaze, rd_type, rd_addr, imem_data, imem_addr} !== '0) begin errors++; $display("FAIL async_reset_outputs: run=%b frame=%h type=%h addr=%h imem=%h expected all 0", run, frame_to_blaze, rd_type, rd_addr, imem_data); end
      @(negedge tb_clock_i);
      tb_reset = 1'b1;
      n0 = n_we;
      send_cmd(CMD_LOAD_INSTR_MSB, 9'h0, 16'h4444, 2);
      checks++; if (n_we - n0 !== 0) begin errors++; $display("FAIL async_reset_lsb_flag: got %0d strobes expected 0", n_we - n0); end
      send_cmd(CMD_LOAD_INSTR_LSB, 9'h0, 16'h5555, 2);
      send_cmd(CMD_LOAD_INSTR_MSB, 9'h0, 16'h6666, 2);
      checks++; if (last_we_addr !== 9'd0 || last_we_data !== 32'h6666_5555) begin errors++; $display("FAIL async_reset_ptr: got %0d/%h expected 0/66665555", last_we_addr, last_we_data); end
      n0 = n_rd_req;
      send_cmd(CMD_REQ_DATA, REQ_LATCH_FETCH_CTRL, 16'h0009, 2);
      checks++; if (n_rd_req - n0 !== 1) begin errors++; $display("FAIL async_reset_idle: got %0d requests expected 1", n_rd_req - n0); end
      give_rd(32'h0000_0099);
      send_cmd(CMD_GOT_DATA, 9'h0, 16'h0, 2);
   endtask

   task automatic test_type_zero();
      int n0;
`ifdef DEBUG_CMD_ERR_EN
      send_cmd(CMD_RESET, 9'h0, 16'h0, 2);
      send_cmd(6'h3F, 9'h0, 16'h0, 2);
      send_cmd(CMD_LOAD_INSTR_MSB, 9'h0, 16'h0, 2);
      send_cmd(CMD_STEP, 9'h0, 16'h0, 2);
      n0 = n_rd_req;
      send_cmd(CMD_REQ_DATA, 9'h000, 16'h0, 2);
      checks++; if (frame_to_blaze !== 32'h0000_0003) begin errors++; $display("FAIL err_count: got %h expected 00000003", frame_to_blaze); end
      checks++; if (n_rd_req - n0 !== 0) begin errors++; $display("FAIL err_count_no_req: got %0d requests expected 0", n_rd_req - n0); end
      send_cmd(CMD_GOT_DATA, 9'h0, 16'h0, 2);
`else
      n0 = n_rd_req;
      send_cmd(CMD_REQ_DATA, 9'h000, 16'h0010, 2);
      checks++; if (n_rd_req - n0 !== 1 || rd_type !== 9'h000 || rd_addr !== 16'h0010) begin errors++; $display("FAIL type0_read: got %0d req type=%h addr=%h expected 1/000/0010", n_rd_req - n0, rd_type, rd_addr); end
      give_rd(32'h0000_00A5);
      checks++; if (frame_to_blaze !== 32'h0000_00A5) begin errors++; $display("FAIL type0_data: got %h expected 000000a5", frame_to_blaze); end
      send_cmd(CMD_GOT_DATA, 9'h0, 16'h0, 2);
`endif
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_reset_cmd();
      test_step_mode();
      test_imem_load();
      test_read();
      test_timeout();
      test_async_reset();
      test_type_zero();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
